// File: rtl/exp_gate_pkg.sv
// Shared constants and the per-lane boolean core for the exp_gate family.
package exp_gate_pkg;

    // Default lane count when a parent does not override WIDTH.
    localparam int unsigned DEF_WIDTH = 1;

    // Per-lane reset values. They are replicated across WIDTH by the user,
    // and XBAR_RST is always the complement of X_RST.
    localparam logic X_RST    = 1'b0;
    localparam logic XBAR_RST = 1'b1;

    // Single-lane 2-wide AND-OR: (a & b) | (c & d).
    function automatic logic and_or2(input logic a, input logic b,
                                     input logic c, input logic d);
        return (a & b) | (c & d);
    endfunction

endpackage

// File: rtl/exp_gate_1_if.sv
// Data bundle for exp_gate_1: four operand vectors in, true/complement pair out.
interface exp_gate_1_if #(
    parameter int unsigned WIDTH = exp_gate_pkg::DEF_WIDTH
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] C;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] XBAR;

    // Source side: drives operands, observes the result pair.
    modport master (
        output A, B, C, D,
        input  X, XBAR
    );

    // Gate side: consumes operands, produces the result pair.
    modport slave (
        input  A, B, C, D,
        output X, XBAR
    );
endinterface

// File: rtl/exp_and_or_lane.sv
// Combinational single-bit AND-OR core; one instance per lane.
module exp_and_or_lane
    import exp_gate_pkg::*;
(
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    input  logic i_d,
    output logic o_f
);

    assign o_f = and_or2(i_a, i_b, i_c, i_d);

endmodule

// File: rtl/exp_gate_1.sv
// Registered 2-wide AND-OR expander gate with true and complementary outputs.
// X = (A & B) | (C & D) per lane; XBAR = ~X. Both outputs come from the same
// value so the pair can never skew, including during reset.
module exp_gate_1
    import exp_gate_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter bit          REG_OUT = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    exp_gate_1_if.slave   bus
);

    logic [WIDTH-1:0] w_f;

    for (genvar gi = 0; gi < int'(WIDTH); gi++) begin : g_lane
        exp_and_or_lane u_lane (
            .i_a (bus.A[gi]),
            .i_b (bus.B[gi]),
            .i_c (bus.C[gi]),
            .i_d (bus.D[gi]),
            .o_f (w_f[gi])
        );
    end

    if (REG_OUT) begin : g_reg
        logic [WIDTH-1:0] r_x;

        // Output register: reset wins over data on the same edge.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_x <= {WIDTH{X_RST}};
            end else begin
                r_x <= w_f;
            end
        end

        // XBAR is derived from r_x rather than held in its own flop, so the
        // reset value ~X_RST equals XBAR_RST by construction.
        assign bus.X    = r_x;
        assign bus.XBAR = ~r_x;
    end else begin : g_comb
        // Clock and reset have no function in the bypass build.
        logic w_unused_clk_rst;
        assign w_unused_clk_rst = clk ^ rst;

        assign bus.X    = w_f;
        assign bus.XBAR = ~w_f;
    end

endmodule

// File: tb/tb_exp_gate_1.sv
// Scoreboard bench for exp_gate_1: a 1-lane and a 4-lane registered gate plus
// a 4-lane combinational gate share one stimulus stream and one reset.
module tb_exp_gate_1;

    typedef struct {
        logic       x1;
        logic [3:0] x4;
    } exp_t;

    logic clk;
    logic rst;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t q_exp[$];

    exp_gate_1_if #(.WIDTH(1)) if1 ();
    exp_gate_1_if #(.WIDTH(4)) if4 ();
    exp_gate_1_if #(.WIDTH(4)) ifc ();

    exp_gate_1 #(.WIDTH(1), .REG_OUT(1'b1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    exp_gate_1 #(.WIDTH(4), .REG_OUT(1'b1)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (if4)
    );

    exp_gate_1 #(.WIDTH(4), .REG_OUT(1'b0)) dutc (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: a lane is 1 when either pair has both operands set,
    // counted arithmetically.
    function automatic logic [3:0] ref_f(input logic [3:0] a, input logic [3:0] b,
                                         input logic [3:0] c, input logic [3:0] d);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) begin
            int s_ab;
            int s_cd;
            s_ab = int'(a[i]) + int'(b[i]);
            s_cd = int'(c[i]) + int'(d[i]);
            r[i] = (s_ab == 2) || (s_cd == 2);
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Drive one cycle of stimulus away from the active edge and queue what the
    // registered gates must show after the next rising edge.
    task automatic apply(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d, input logic r);
        exp_t       e;
        logic [3:0] f;
        @(negedge clk);
        rst    = r;
        if1.A  = a[0:0];
        if1.B  = b[0:0];
        if1.C  = c[0:0];
        if1.D  = d[0:0];
        if4.A  = a;
        if4.B  = b;
        if4.C  = c;
        if4.D  = d;
        ifc.A  = a;
        ifc.B  = b;
        ifc.C  = c;
        ifc.D  = d;
        f      = ref_f(a, b, c, d);
        e.x1   = r ? 1'b0 : f[0];
        e.x4   = r ? 4'h0 : f;
        q_exp.push_back(e);
        #1;
        // Bypass build: immediate, unaffected by rst.
        check("comb_x", ifc.X, f);
        check("comb_xbar", ifc.XBAR, ~f);
    endtask

    // Monitor: one result per cycle, sampled just after the rising edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            check("w1_x", {3'b000, if1.X}, {3'b000, e.x1});
            check("w1_xbar", {3'b000, if1.XBAR}, {3'b000, ~e.x1});
            check("w4_x", if4.X, e.x4);
            check("w4_xbar", if4.XBAR, ~e.x4);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] c;
        logic [3:0] d;
        logic [3:0] v;

        rst   = 1'b1;
        if1.A = '1;
        if1.B = '1;
        if1.C = '1;
        if1.D = '1;
        if4.A = '1;
        if4.B = '1;
        if4.C = '1;
        if4.D = '1;
        ifc.A = '1;
        ifc.B = '1;
        ifc.C = '1;
        ifc.D = '1;

        // Reset held for two edges with all operands high.
        apply(4'hF, 4'hF, 4'hF, 4'hF, 1'b1);
        apply(4'hF, 4'hF, 4'hF, 4'hF, 1'b1);

        // All-zero, then expander operand C alone.
        apply(4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        apply(4'h0, 4'h0, 4'hF, 4'h0, 1'b0);

        // Exhaustive truth table on lane 0; upper lanes randomized.
        for (int i = 0; i < 16; i++) begin
            v = 4'(i);
            a = {3'($urandom), v[3]};
            b = {3'($urandom), v[2]};
            c = {3'($urandom), v[1]};
            d = {3'($urandom), v[0]};
            apply(a, b, c, d, 1'b0);
        end

        // Back-to-back toggling 1100 / 0000.
        for (int i = 0; i < 4; i++) begin
            apply(4'hF, 4'hF, 4'h0, 4'h0, 1'b0);
            apply(4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        end

        // Mid-stream reset discards the in-flight result.
        apply(4'hF, 4'hF, 4'hF, 4'hF, 1'b0);
        apply(4'hF, 4'hF, 4'hF, 4'hF, 1'b1);
        apply(4'hF, 4'hF, 4'hF, 4'hF, 1'b0);

        // Lane independence: expect X=1001, XBAR=0110.
        apply(4'b1010, 4'b1100, 4'b0101, 4'b0011, 1'b0);

        // Random traffic with occasional reset.
        for (int i = 0; i < 300; i++) begin
            apply(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                  ($urandom_range(0, 15) == 0));
        end

        // Drain: the last queued result must have been consumed.
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (q_exp.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending, expected 0", q_exp.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
